engine_batch_scheduler: RTL and testbench

//  Sequences the NUM_ENGINES pixel engines fed by the raster coordinate distributor.
//  Per batch: pulses eng_start, waits for every engine's done, captures all results, streams them out in raster order (valid/ready).

---
 rtl/render_pkg.sv | 24 ++
 rtl/raster_counter.sv | 39 +++
 rtl/engine_batch_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_engine_batch_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// Shared defaults and scheduler state encoding for the pixel-engine pipeline.
package render_pkg;

  localparam int unsigned DefNumEngines     = 30;
  localparam int unsigned DefIterWidth      = 8;
  localparam int unsigned DefScreenWidth    = 640;
  localparam int unsigned DefScreenHeight   = 480;
  localparam int unsigned DefPixelDataWidth = 10;
  localparam int unsigned DefTimeoutCycles  = 4096;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StDrain,
    StAdvance
  } sched_state_t;

  // Index width that stays legal for a single-entry buffer.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position tracker: x/y advance once per accepted beat, with line and frame wrap.
// sof/eol describe the current position, not the validity of any beat.
module raster_counter #(
  parameter int unsigned SCREEN_WIDTH     = 640,
  parameter int unsigned SCREEN_HEIGHT    = 480,
  parameter int unsigned PIXEL_DATA_WIDTH = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic advance,
  output logic sof,
  output logic eol
);

  localparam logic [PIXEL_DATA_WIDTH-1:0] XLast = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] YLast = PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1);

  logic [PIXEL_DATA_WIDTH-1:0] x_q;
  logic [PIXEL_DATA_WIDTH-1:0] y_q;

  // Step x per beat; end of line bumps y, end of frame returns to origin
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (advance) begin
      if (x_q == XLast) begin
        x_q <= '0;
        y_q <= (y_q == YLast) ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign sof = (x_q == '0) && (y_q == '0);
  assign eol = (x_q == XLast);

endmodule

// File: rtl/engine_batch_scheduler.sv
// Batch scheduler for the pixel-engine array: start all engines, wait for every done,
// snapshot the results, stream them out in raster order, then advance the distributor.
// Optional build macro BATCH_TIMEOUT_EN adds a WAIT watchdog that forces a capture after
// TIMEOUT_CYCLES, substitutes all-ones for unfinished engines and sets sticky err_timeout.
module engine_batch_scheduler
  import render_pkg::*;
#(
  parameter int unsigned NUM_ENGINES      = DefNumEngines,
  parameter int unsigned ITER_WIDTH       = DefIterWidth,
  parameter int unsigned SCREEN_WIDTH     = DefScreenWidth,
  parameter int unsigned SCREEN_HEIGHT    = DefScreenHeight,
  parameter int unsigned PIXEL_DATA_WIDTH = DefPixelDataWidth,
  parameter int unsigned TIMEOUT_CYCLES   = DefTimeoutCycles
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  output logic                              eng_start,
  input  logic [NUM_ENGINES-1:0]            eng_done,
  input  logic [NUM_ENGINES*ITER_WIDTH-1:0] eng_result,
  output logic                              fin_flag,
  output logic [ITER_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_sof,
  output logic                              out_eol,
  output logic                              busy,
  output logic                              err_timeout
);

  localparam int unsigned IdxW = idx_width(NUM_ENGINES);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_ENGINES - 1);

  sched_state_t                     state_q;
  logic [IdxW-1:0]                  idx_q;
  logic [ITER_WIDTH-1:0]            res_buf_q [NUM_ENGINES];
  logic                             eng_start_q;
  logic                             fin_flag_q;
  logic                             out_valid_q;
  logic                             busy_q;

  logic                             all_done;
  logic                             capture;
  logic                             beat;
  logic [NUM_ENGINES*ITER_WIDTH-1:0] capture_data;
  logic                             raster_sof;
  logic                             raster_eol;

  assign all_done = &eng_done;
  assign beat     = out_valid_q & out_ready;

`ifdef BATCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] wait_cnt_q;
  logic            err_timeout_q;
  logic            timeout_hit;

  // Last permitted WAIT cycle reached with at least one engine still running
  assign timeout_hit = (state_q == StWait) && !all_done && (wait_cnt_q == CntLast);

  // Watchdog: count WAIT cycles from the first one; latch the error until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == StWait) ? wait_cnt_q + 1'b1 : '0;
      if (timeout_hit) begin
        err_timeout_q <= 1'b1;
      end
    end
  end

  // Unfinished engines report the maximum iteration count
  always_comb begin
    capture_data = eng_result;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (!eng_done[i]) begin
        capture_data[i*ITER_WIDTH +: ITER_WIDTH] = '1;
      end
    end
  end

  assign capture     = (state_q == StWait) && (all_done || timeout_hit);
  assign err_timeout = err_timeout_q;
`else
  assign capture_data = eng_result;
  assign capture      = (state_q == StWait) && all_done;
  assign err_timeout  = 1'b0;
`endif

  // Snapshot every engine result in the single capture cycle
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        res_buf_q[i] <= capture_data[i*ITER_WIDTH +: ITER_WIDTH];
      end
    end
  end

  // Batch sequencer; strobes and flags are registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      eng_start_q <= 1'b0;
      fin_flag_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      fin_flag_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_q     <= StStart;
            eng_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        // Done flags may still be stale here; engines clear them on this strobe
        StStart: begin
          state_q <= StWait;
        end
        StWait: begin
          if (capture) begin
            state_q     <= StDrain;
            out_valid_q <= 1'b1;
            idx_q       <= '0;
          end
        end
        StDrain: begin
          if (beat) begin
            if (idx_q == IdxLast) begin
              state_q     <= StAdvance;
              out_valid_q <= 1'b0;
              fin_flag_q  <= 1'b1;
              idx_q       <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        // Distributor advances on this edge, so the next start sees fresh coordinates
        StAdvance: begin
          if (enable) begin
            state_q     <= StStart;
            eng_start_q <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  raster_counter #(
    .SCREEN_WIDTH    (SCREEN_WIDTH),
    .SCREEN_HEIGHT   (SCREEN_HEIGHT),
    .PIXEL_DATA_WIDTH(PIXEL_DATA_WIDTH)
  ) u_raster (
    .clk    (clk),
    .reset  (reset),
    .advance(beat),
    .sof    (raster_sof),
    .eol    (raster_eol)
  );

  assign eng_start = eng_start_q;
  assign fin_flag  = fin_flag_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = out_valid_q ? res_buf_q[idx_q] : '0;
  assign out_sof   = raster_sof & out_valid_q;
  assign out_eol   = raster_eol & out_valid_q;

endmodule

// File: tb/tb_engine_batch_scheduler.sv
// Directed bench with a beat scoreboard for engine_batch_scheduler.
// A reduced 40x6 screen keeps line and frame wrap within a short run.
module tb_engine_batch_scheduler;

  localparam int NE  = 30;
  localparam int IW  = 8;
  localparam int SW  = 40;
  localparam int SH  = 6;
  localparam int PDW = 10;
  localparam int TO  = 64;
  localparam int FR  = SW * SH;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic            out_ready = 1'b1;
  logic            eng_start, fin_flag, out_valid, out_sof, out_eol, busy, err_timeout;
  logic [NE-1:0]   eng_done;
  logic [NE*IW-1:0] eng_result;
  logic [IW-1:0]   out_data;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [9:0] exp_q[$];
  int   delay[NE];
  logic stuck[NE];
  int   cnt[NE];
  int   seed = 0;
  int   mx = 0;
  int   my = 0;
  int   beats_seen = 0, sof_seen = 0, eol_seen = 0, starts_seen = 0;
  logic rand_ready = 1'b0;

  engine_batch_scheduler #(
    .NUM_ENGINES     (NE),
    .ITER_WIDTH      (IW),
    .SCREEN_WIDTH    (SW),
    .SCREEN_HEIGHT   (SH),
    .PIXEL_DATA_WIDTH(PDW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .eng_start  (eng_start),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .fin_flag   (fin_flag),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Expected beats for one batch, with raster position tracked independently
  function automatic void push_batch();
    logic [IW-1:0] v;
    for (int i = 0; i < NE; i++) begin
      v = stuck[i] ? {IW{1'b1}} : IW'(seed + i);
      exp_q.push_back({(mx == 0 && my == 0), (mx == SW - 1), v});
      mx++;
      if (mx == SW) begin
        mx = 0;
        my++;
        if (my == SH) my = 0;
      end
    end
  endfunction

  // Engine array model: latch on start, raise done after a per-engine delay
  always @(posedge clk) begin
    if (reset) begin
      eng_done   <= '0;
      eng_result <= '0;
      for (int i = 0; i < NE; i++) cnt[i] <= 0;
    end else if (eng_start) begin
      eng_done <= '0;
      for (int i = 0; i < NE; i++) begin
        cnt[i] <= delay[i];
        eng_result[i*IW +: IW] <= IW'(seed + i);
      end
      push_batch();
      seed = seed + 7;
    end else begin
      for (int i = 0; i < NE; i++) begin
        if (!eng_done[i] && !stuck[i]) begin
          if (cnt[i] == 0) eng_done[i] <= 1'b1;
          else cnt[i] <= cnt[i] - 1;
        end
      end
    end
  end

  // Output monitor, sampled mid-cycle
  logic       prev_start = 1'b0, prev_fin = 1'b0, prev_en = 1'b0, hold_pending = 1'b0;
  logic [9:0] held;
  logic [9:0] e;
  always @(negedge clk) begin
    if (reset) begin
      prev_start   = 1'b0;
      prev_fin     = 1'b0;
      hold_pending = 1'b0;
    end else begin
      if (hold_pending)
        check("stall_hold", {out_valid, out_sof, out_eol, out_data}, {1'b1, held});
      hold_pending = out_valid && !out_ready;
      held = {out_sof, out_eol, out_data};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat", {out_sof, out_eol, out_data}, e);
        end
        beats_seen++;
        sof_seen += int'(out_sof);
        eol_seen += int'(out_eol);
      end
      if (!out_valid) check("flags_idle", {out_sof, out_eol}, 0);
      if (prev_start) check("start_width", eng_start, 0);
      if (prev_fin) begin
        check("fin_width", fin_flag, 0);
        check("start_after_fin", eng_start, prev_en);
      end
      if (fin_flag) check("fin_drained", exp_q.size(), 0);
      if (eng_start) begin
        check("start_q_empty", exp_q.size(), 0);
        starts_seen++;
      end
      prev_start = eng_start;
      prev_fin   = fin_flag;
      prev_en    = enable;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return eng_start;
      1:       return out_valid;
      default: return fin_flag;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int sel, input int limit, output int w);
    w = 0;
    while (!sig(sel) && w < limit) begin
      tick();
      w++;
    end
    if (!sig(sel)) check(tag, sig(sel), 1);
  endtask

  task automatic run_batch(output int lat);
    int c0, b0, s0, w;
    b0 = beats_seen;
    s0 = starts_seen;
    wait_sig("wait_start", 0, 300, w);
    c0 = cyc;
    wait_sig("wait_valid", 1, 600, w);
    lat = cyc - c0;
    wait_sig("wait_fin", 2, 2000, w);
    check("batch_beats", beats_seen - b0, NE);
    check("batch_starts", starts_seen - s0, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_eng_start"}, eng_start, 0);
    check({tag, "_fin_flag"}, fin_flag, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_sof"}, out_sof, 0);
    check({tag, "_out_eol"}, out_eol, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_timeout"}, err_timeout, 0);
    check({tag, "_out_data"}, out_data, 0);
  endtask

  initial begin
    int lat;
    int s0;
    for (int i = 0; i < NE; i++) begin
      delay[i] = 3;
      stuck[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // T1: results 0..29, done 5 cycles after start
    enable = 1'b1;
    run_batch(lat);
    check("t1_latency", lat, 6);
    check("t1_sof_count", sof_seen, 1);
    check("t1_busy", busy, 1);

    // T2: randomly stalled sink
    rand_ready = 1'b1;
    run_batch(lat);
    rand_ready = 1'b0;
    out_ready = 1'b1;

    // T3/T4: line wraps and a frame wrap
    for (int b = 0; b < 16; b++) run_batch(lat);
    check("t4_sof_count", sof_seen, (beats_seen + FR - 1) / FR);
    check("t3_eol_count", eol_seen, beats_seen / SW);

    // T5: one slow engine
    delay[29] = 103;
    run_batch(lat);
    check("t5_latency", lat, 106);
    delay[29] = 3;

    // T6: drop enable during DRAIN, then reset inside WAIT
    wait_sig("t6_wait_valid", 1, 600, lat);
    enable = 1'b0;
    wait_sig("t6_wait_fin", 2, 2000, lat);
    s0 = starts_seen;
    repeat (6) tick();
    check("t6_idle_busy", busy, 0);
    check("t6_no_start", starts_seen - s0, 0);
    enable = 1'b1;
    wait_sig("t6_wait_start", 0, 300, lat);
    repeat (2) tick();
    check("t6_wait_busy", busy, 1);
    reset = 1'b1;
    enable = 1'b0;
    exp_q.delete();
    mx = 0;
    my = 0;
    tick();
    check_outputs_zero("t6_reset");
    reset = 1'b0;
    tick();

`ifdef BATCH_TIMEOUT_EN
    // T7: engine 3 never finishes
    stuck[3] = 1'b1;
    enable = 1'b1;
    run_batch(lat);
    check("t7_latency", lat, TO + 1);
    check("t7_err_timeout", err_timeout, 1);
    stuck[3] = 1'b0;
    run_batch(lat);
    check("t7_latency_after", lat, 6);
    check("t7_err_sticky", err_timeout, 1);
    enable = 1'b0;
`else
    enable = 1'b1;
    run_batch(lat);
    check("post_reset_latency", lat, 6);
    check("err_timeout_tied", err_timeout, 0);
    enable = 1'b0;
`endif

    repeat (4) tick();
    check("end_queue_empty", exp_q.size(), 0);
    check("end_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
